// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared LFSR constants, FSM state type and step function
package rng_pkg;

  localparam int LFSR_W = 31;
  localparam int TAP_A  = 30;
  localparam int TAP_B  = 27;
  localparam int TAP_C  = 5;

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_READY   = 2'd1,
    ST_STEP    = 2'd2,
    ST_DELIVER = 2'd3
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C]};
  endfunction

endpackage

// File: rtl/rng_arbiter_if.sv
// rtl/rng_arbiter_if.sv - requester-side request/grant/word bundle
interface rng_arbiter_if #(
  parameter int NREQ = 4
);
  import rng_pkg::*;

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic [LFSR_W-1:0] rnd_data;
  logic              rnd_valid;

  modport master (output req, input gnt, input rnd_data, input rnd_valid);
  modport slave  (input req, output gnt, output rnd_data, output rnd_valid);

endinterface

// File: rtl/lfsr31_step.sv
// rtl/lfsr31_step.sv - 31-bit Fibonacci LFSR register with load and shift enables
module lfsr31_step
  import rng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_VAL = 31'h2545_F491
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [LFSR_W-1:0] load_val_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  // A load always beats a shift so a reseed lands exactly as given.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_val_i;
    end else if (shift_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/rng_arbiter.sv
// rtl/rng_arbiter.sv - seeds, warms up and shares one LFSR among NREQ round-robin requesters
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int                NREQ         = 4,
  parameter int                STEPS        = 31,
  parameter int                WARMUP       = 64,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 31'h2545_F491
) (
  input  logic              qzt_clk,
  input  logic              reset_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic              busy,
  rng_arbiter_if.slave      bus
);

  localparam int IDX_W = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [9:0]        warm_cnt_q, warm_cnt_d;
  logic [7:0]        step_cnt_q, step_cnt_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  winner_q, winner_d;
  logic [LFSR_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  pick_idx;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] load_val;
  logic              lfsr_load, lfsr_shift, deliver;

  assign load_val = (seed == '0) ? DEFAULT_SEED : seed;

  lfsr31_step #(.RESET_VAL(DEFAULT_SEED)) u_lfsr (
    .clk_i      (qzt_clk),
    .rst_ni     (reset_n),
    .load_i     (lfsr_load),
    .shift_i    (lfsr_shift),
    .load_val_i (load_val),
    .state_o    (lfsr_q)
  );

  // Descending scan so the lowest offset from rr_q is the last (winning) write.
  always_comb begin
    pick_idx = rr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[IDX_W'((int'(rr_q) + i) % NREQ)]) begin
        pick_idx = IDX_W'((int'(rr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    step_cnt_d = step_cnt_q;
    rr_d       = rr_q;
    winner_d   = winner_q;
    data_d     = data_q;
    lfsr_load  = 1'b0;
    lfsr_shift = 1'b0;
    deliver    = 1'b0;
    if (seed_load) begin
      lfsr_load  = 1'b1;
      warm_cnt_d = '0;
      state_d    = ST_WARMUP;
    end else begin
      unique case (state_q)
        ST_WARMUP: begin
          if (WARMUP == 0) begin
            state_d = ST_READY;
          end else begin
            lfsr_shift = 1'b1;
            warm_cnt_d = warm_cnt_q + 10'd1;
            if (warm_cnt_q == 10'(WARMUP - 1)) state_d = ST_READY;
          end
        end
        ST_READY: begin
          if (|bus.req) begin
            winner_d   = pick_idx;
            step_cnt_d = '0;
            state_d    = ST_STEP;
          end
        end
        ST_STEP: begin
          lfsr_shift = 1'b1;
          step_cnt_d = step_cnt_q + 8'd1;
          if (step_cnt_q == 8'(STEPS - 1)) state_d = ST_DELIVER;
        end
        ST_DELIVER: begin
          deliver = 1'b1;
          data_d  = lfsr_q;
          rr_d    = (winner_q == IDX_W'(NREQ - 1)) ? '0 : winner_q + 1'b1;
          state_d = ST_READY;
        end
        default: state_d = ST_WARMUP;
      endcase
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (!reset_n) begin
      state_q    <= ST_WARMUP;
      warm_cnt_q <= '0;
      step_cnt_q <= '0;
      rr_q       <= '0;
      winner_q   <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      step_cnt_q <= step_cnt_d;
      rr_q       <= rr_d;
      winner_q   <= winner_d;
      data_q     <= data_d;
    end
  end

  // Word and grant are gated combinationally so a same-cycle reseed suppresses them.
  assign bus.rnd_valid = deliver;
  assign bus.gnt       = deliver ? (NREQ'(1) << winner_q) : '0;
  assign bus.rnd_data  = deliver ? lfsr_q : data_q;
  assign busy          = (state_q != ST_READY);

endmodule
